cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) between the add, mul and lw reservation-station result ports.
- Each cycle it grants at most one requester and latches that requester's unit tag and result into a registered broadcast.
- The broadcast drives the RS operand-capture logic and the RRS writeback.
- It replaces direct, race-prone CDB writes from the units with a one-writer, one-cycle-latency bus.

Parameters:
- NUM_REQ, 3, number of requester ports (0=add, 1=mul, 2=lw).
- UNIT_SIZE, 8, width of the unit tag (codes: lw 8'b100xxxxx, add 8'b101xxxxx, mul 8'b110xxxxx).
- WORD_SIZE, 32, result data width.
- MAX_WAIT, 4, wait cycles after which a pending requester becomes aged.
- WAIT_W, 3, width of each per-port wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  NUM_REQ  port i has a result pending.
- req_tag  in  NUM_REQ*UNIT_SIZE  port i tag at bits [i*8 +: 8].
- req_data  in  NUM_REQ*WORD_SIZE  port i result at bits [i*32 +: 32].
- req_ready  out  NUM_REQ  combinational one-hot grant; the transfer occurs when valid and ready are both high.
- hold  in  1  RRS busy; suppresses all grants this cycle.
- flush  in  1  squash; suppresses grants and clears state.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  UNIT_SIZE  broadcast unit tag.
- cdb_data  out  WORD_SIZE  broadcast result.
- cdb_src  out  2  index of the port that produced the broadcast.
- cdb_count  out  16  count of broadcasts issued; wraps.

Behaviour:
- Reset (rst_n=0, async): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, cdb_count=0, rr_ptr=0, all wait counters=0. req_ready=0 while in reset.
- Handshake:
  - A requester holds req_valid, tag and data stable until granted.
  - Dropping req_valid before grant is legal; that request is simply withdrawn.
  - req_ready[i] is asserted only when req_valid[i]=1.
- Grant selection (combinational, no grant when hold=1 or flush=1):
  1. If any port has an aged wait counter (wait[i] >= MAX_WAIT), grant the lowest-index aged port.
  2. Otherwise grant round-robin: search from rr_ptr upward with wraparound and take the first valid port.
- Pointer update on grant of port g: rr_ptr <= (g+1) mod NUM_REQ. No grant leaves rr_ptr unchanged.
- Broadcast latency is 1 cycle. A grant in cycle t gives, in cycle t+1:
  - cdb_valid=1, cdb_tag=req_tag[g], cdb_data=req_data[g], cdb_src=g;
  - cdb_count increments (16-bit wrap, 0xFFFF -> 0x0000).
- With no grant in cycle t, cdb_valid=0 in t+1. cdb_tag and cdb_data hold their last values.
- cdb_valid is never high for two cycles from the same grant.
- Wait counters, per port, each cycle:
  - granted, or req_valid=0 -> 0;
  - valid and not granted, not hold/flush -> increment, saturating at 2^WAIT_W-1;
  - during hold -> unchanged.
- flush=1 (synchronous, priority over hold):
  - no grant; cdb_valid <= 0; rr_ptr <= 0; all wait counters <= 0;
  - cdb_count unchanged.
  - A broadcast already registered (cdb_valid=1 in the flush cycle) remains visible for that cycle only.
- Simultaneous hold and a registered broadcast: the broadcast still completes. hold affects only new grants.
- Tag sanity (assertion only, no RTL effect): the tag class of port i matches its index (add 101, mul 110, lw 100). cdb_tag is never 8'b01111111.
- Reset mid-broadcast: cdb_valid drops immediately and asynchronously. The granted requester is considered served and must not re-present the result.

Decomposition:
- Shared package `cdb_pkg`:
  - UNIT_SIZE, WORD_SIZE;
  - unit code base constants: UNIT_LW=8'b10000000, UNIT_ADD=8'b10100000, UNIT_MUL=8'b11000000, UNIT_MV=8'b01111111;
  - requester index constants REQ_ADD=0, REQ_MUL=1, REQ_LW=2;
  - a packed cdb_t struct {valid, tag, data}.
- One sub-module, `rr_age_picker`: takes valid vector, aged vector and rr_ptr; returns a one-hot grant plus the encoded index. It is purely combinational.
- The top level holds the registers, wait counters and broadcast logic.

Test Plan:
- Single requester: port 0 valid with tag 8'hA3, data 32'd7 for 1 cycle -> req_ready[0]=1 in cycle 0. In cycle 1: cdb_valid=1, cdb_tag=A3, cdb_data=7, cdb_src=0, cdb_count=1.
- Round-robin: all 3 ports continuously valid from reset for 6 cycles -> grant order 0,1,2,0,1,2; cdb_valid high cycles 1..6; no aging triggered.
- Aging: MAX_WAIT=2, port 1 valid for a long run while hold=1 for 3 cycles -> wait counters unchanged during hold. Then ports 1 and 2 wait with rr_ptr=2 -> port 2 granted; once wait[1] reaches 2, port 1 is granted next, ahead of round-robin.
- Hold: hold=1 for 4 cycles with all ports valid -> req_ready=0, cdb_valid=0 from cycle 1, rr_ptr unchanged. After release, the first grant goes to the port at rr_ptr.
- Flush: broadcast pending (cdb_valid=1) with flush=1 in the same cycle -> broadcast visible that cycle; next cycle cdb_valid=0, rr_ptr=0, wait counters 0, cdb_count unchanged.
- Async reset: assert rst_n=0 mid-cycle while cdb_valid=1 and cdb_count=0xFFFF -> outputs zero immediately without a clock edge. Separately, with 0xFFFF preloaded and no reset, one grant wraps cdb_count to 0x0000.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter: unit tag codes,
// requester indices and the broadcast record.
package cdb_pkg;

  localparam int UNIT_SIZE = 8;
  localparam int WORD_SIZE = 32;

  localparam logic [UNIT_SIZE-1:0] UNIT_LW  = 8'b1000_0000;
  localparam logic [UNIT_SIZE-1:0] UNIT_ADD = 8'b1010_0000;
  localparam logic [UNIT_SIZE-1:0] UNIT_MUL = 8'b1100_0000;
  localparam logic [UNIT_SIZE-1:0] UNIT_MV  = 8'b0111_1111;

  localparam int REQ_ADD = 0;
  localparam int REQ_MUL = 1;
  localparam int REQ_LW  = 2;

  typedef struct packed {
    logic                 valid;
    logic [UNIT_SIZE-1:0] tag;
    logic [WORD_SIZE-1:0] data;
  } cdb_t;

  // Top three tag bits identify the unit class expected on each requester port.
  function automatic logic [2:0] unit_class(input int idx);
    case (idx)
      REQ_ADD: return UNIT_ADD[UNIT_SIZE-1 -: 3];
      REQ_MUL: return UNIT_MUL[UNIT_SIZE-1 -: 3];
      REQ_LW:  return UNIT_LW[UNIT_SIZE-1 -: 3];
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rr_age_picker.sv
// Combinational grant picker: lowest-index aged requester wins, otherwise the
// first valid requester found searching upward from the round-robin pointer.
module rr_age_picker #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [NUM_REQ-1:0] i_aged,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  // Loops run downward so the last match written is the highest-priority one.
  always_comb begin
    int w_p;
    w_p     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    if (|i_aged) begin
      o_any = 1'b1;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_aged[i]) o_idx = PTR_W'(i);
      end
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_p = int'(i_rr_ptr) + k;
        if (w_p >= NUM_REQ) w_p = w_p - NUM_REQ;
        if (i_valid[w_p]) begin
          o_idx = PTR_W'(w_p);
          o_any = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = o_any && (o_idx == PTR_W'(i));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one result port per cycle (aging, then
// round-robin) and registers its tag/data as a one-cycle-latency broadcast.
module cdb_arbiter
  import cdb_pkg::UNIT_MV;
  import cdb_pkg::unit_class;
#(
  parameter int NUM_REQ   = 3,
  parameter int UNIT_SIZE = 8,
  parameter int WORD_SIZE = 32,
  parameter int MAX_WAIT  = 4,
  parameter int WAIT_W    = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UNIT_SIZE-1:0]   req_tag,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           hold,
  input  logic                           flush,
  output logic                           cdb_valid,
  output logic [UNIT_SIZE-1:0]           cdb_tag,
  output logic [WORD_SIZE-1:0]           cdb_data,
  output logic [1:0]                     cdb_src,
  output logic [15:0]                    cdb_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     r_rr_ptr;
  logic [WAIT_W-1:0]    r_wait [NUM_REQ];
  logic                 r_cdb_valid;
  logic [UNIT_SIZE-1:0] r_cdb_tag;
  logic [WORD_SIZE-1:0] r_cdb_data;
  logic [1:0]           r_cdb_src;
  logic [15:0]          r_cdb_count;

  logic [NUM_REQ-1:0]   w_aged;
  logic [NUM_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_any;
  logic                 w_en;
  logic                 w_fire;

  // A stale counter on a withdrawn port must not win arbitration.
  always_comb begin
    w_aged = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_aged[i] = req_valid[i] && (r_wait[i] >= WAIT_W'(MAX_WAIT));
    end
  end

  rr_age_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_valid  (req_valid),
    .i_aged   (w_aged),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_en      = rst_n & ~hold & ~flush;
  assign w_fire    = w_en & w_any;
  assign req_ready = w_grant & {NUM_REQ{w_en}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
      r_cdb_count <= '0;
      r_rr_ptr    <= '0;
    end else if (flush) begin
      r_cdb_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_cdb_valid <= w_fire;
      if (w_fire) begin
        r_cdb_tag   <= req_tag[int'(w_idx)*UNIT_SIZE +: UNIT_SIZE];
        r_cdb_data  <= req_data[int'(w_idx)*WORD_SIZE +: WORD_SIZE];
        r_cdb_src   <= 2'(w_idx);
        r_cdb_count <= r_cdb_count + 16'd1;
        r_rr_ptr    <= (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  // Waiting ports age only on cycles where a grant was actually possible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush || !req_valid[i] || req_ready[i]) begin
          r_wait[i] <= '0;
        end else if (!hold && (r_wait[i] != '1)) begin
          r_wait[i] <= r_wait[i] + 1'b1;
        end
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;
  assign cdb_count = r_cdb_count;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tag_class
    a_tag_class: assert property (@(posedge clk) disable iff (!rst_n)
      req_valid[gi] |-> (req_tag[gi*UNIT_SIZE + UNIT_SIZE - 3 +: 3] == unit_class(gi)));
  end

  a_no_mv_tag: assert property (@(posedge clk) disable iff (!rst_n)
    cdb_tag != UNIT_MV);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the bus.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NREQ  = 3;
  localparam int MAXW  = 2;
  localparam int WBITS = 3;
  localparam int WSAT  = 7;

  logic        clk;
  logic        rst_n;
  logic [2:0]  reqValid;
  logic [23:0] reqTag;
  logic [95:0] reqData;
  logic [2:0]  reqReady;
  logic        hold;
  logic        flush;
  logic        cdbValid;
  logic [7:0]  cdbTag;
  logic [31:0] cdbData;
  logic [1:0]  cdbSrc;
  logic [15:0] cdbCount;

  int checkCount;
  int errorCount;

  cdb_t       mCdb;
  int         mSrc;
  int         mCount;
  int         mPtr;
  int         mWait [NREQ];
  logic [2:0] lastGrant;

  cdb_arbiter #(
    .NUM_REQ   (NREQ),
    .UNIT_SIZE (8),
    .WORD_SIZE (32),
    .MAX_WAIT  (MAXW),
    .WAIT_W    (WBITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (reqValid),
    .req_tag   (reqTag),
    .req_data  (reqData),
    .req_ready (reqReady),
    .hold      (hold),
    .flush     (flush),
    .cdb_valid (cdbValid),
    .cdb_tag   (cdbTag),
    .cdb_data  (cdbData),
    .cdb_src   (cdbSrc),
    .cdb_count (cdbCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  // Port class bits: add=101, mul=110, lw=100.
  function automatic logic [7:0] makeTag(input int port, input logic [4:0] low);
    case (port)
      0:       return {3'b101, low};
      1:       return {3'b110, low};
      default: return {3'b100, low};
    endcase
  endfunction

  task automatic loadPort(input int port);
    reqTag[port*8 +: 8]   = makeTag(port, 5'($urandom));
    reqData[port*32 +: 32] = $urandom;
  endtask

  task automatic resetModel();
    mCdb      = '0;
    mSrc      = 0;
    mCount    = 0;
    mPtr      = 0;
    lastGrant = '0;
    for (int i = 0; i < NREQ; i++) mWait[i] = 0;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (reqValid[i] && !lastGrant[i]) begin
        if ($urandom_range(0, 9) == 0) reqValid[i] = 1'b0;
      end else begin
        reqValid[i] = ($urandom_range(0, 9) < 6);
        loadPort(i);
      end
    end
    hold  = ($urandom_range(0, 99) < 15);
    flush = ($urandom_range(0, 99) < 5);
  endtask

  // One clock: check the combinational grant, advance the model at the edge,
  // then check the registered broadcast on the following falling edge.
  task automatic tick();
    int g;
    logic fire;
    logic [2:0] expReady;
    #1;
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (g < 0 && reqValid[i] && mWait[i] >= MAXW) g = i;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && reqValid[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
    end
    fire     = (g >= 0) && !hold && !flush;
    expReady = fire ? (3'b001 << g) : 3'b000;
    checkOutput("req_ready", 32'(reqReady), 32'(expReady));
    @(posedge clk);
    lastGrant = expReady;
    for (int i = 0; i < NREQ; i++) begin
      if (flush || !reqValid[i] || expReady[i]) mWait[i] = 0;
      else if (!hold && mWait[i] < WSAT) mWait[i] = mWait[i] + 1;
    end
    if (flush) begin
      mCdb.valid = 1'b0;
      mPtr       = 0;
    end else begin
      mCdb.valid = fire;
      if (fire) begin
        mCdb.tag  = reqTag[g*8 +: 8];
        mCdb.data = reqData[g*32 +: 32];
        mSrc      = g;
        mCount    = (mCount + 1) % 65536;
        mPtr      = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
    checkOutput("cdb_valid", 32'(cdbValid), 32'(mCdb.valid));
    checkOutput("cdb_tag",   32'(cdbTag),   32'(mCdb.tag));
    checkOutput("cdb_data",  cdbData,       mCdb.data);
    checkOutput("cdb_src",   32'(cdbSrc),   32'(mSrc));
    checkOutput("cdb_count", 32'(cdbCount), 32'(mCount));
  endtask

  initial begin
    int savedPtr;
    checkCount = 0;
    errorCount = 0;
    resetModel();
    rst_n    = 1'b0;
    hold     = 1'b0;
    flush    = 1'b0;
    reqValid = 3'b111;
    for (int i = 0; i < NREQ; i++) loadPort(i);

    #3;
    checkOutput("reset_ready", 32'(reqReady), 32'h0);
    checkOutput("reset_valid", 32'(cdbValid), 32'h0);
    checkOutput("reset_tag",   32'(cdbTag),   32'h0);
    checkOutput("reset_data",  cdbData,       32'h0);
    checkOutput("reset_src",   32'(cdbSrc),   32'h0);
    checkOutput("reset_count", 32'(cdbCount), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    reqValid = 3'b000;
    tick();

    $display("[TB] single requester");
    reqValid = 3'b001;
    reqTag[7:0]   = 8'hA3;
    reqData[31:0] = 32'd7;
    tick();
    checkOutput("single_valid", 32'(cdbValid), 32'h1);
    checkOutput("single_tag",   32'(cdbTag),   32'hA3);
    checkOutput("single_data",  cdbData,       32'd7);
    checkOutput("single_src",   32'(cdbSrc),   32'h0);
    checkOutput("single_count", 32'(cdbCount), 32'h1);
    reqValid = 3'b000;
    tick();

    $display("[TB] round robin");
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    reqValid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      tick();
      checkOutput("rr_src", 32'(cdbSrc), 32'(c % 3));
      checkOutput("rr_valid", 32'(cdbValid), 32'h1);
    end

    $display("[TB] hold");
    savedPtr = mPtr;
    hold     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("hold_valid", 32'(cdbValid), 32'h0);
    end
    hold = 1'b0;
    tick();
    checkOutput("hold_release_src", 32'(cdbSrc), 32'(savedPtr));

    $display("[TB] flush with broadcast pending");
    flush = 1'b1;
    #1;
    checkOutput("flush_visible", 32'(cdbValid), 32'h1);
    tick();
    checkOutput("flush_cleared", 32'(cdbValid), 32'h0);
    flush = 1'b0;

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      applyStimulus();
      tick();
    end

    $display("[TB] async reset mid-broadcast");
    hold     = 1'b0;
    flush    = 1'b0;
    reqValid = 3'b111;
    for (int i = 0; i < NREQ; i++) loadPort(i);
    tick();
    checkOutput("pre_reset_valid", 32'(cdbValid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 32'(cdbValid), 32'h0);
    checkOutput("areset_tag",   32'(cdbTag),   32'h0);
    checkOutput("areset_data",  cdbData,       32'h0);
    checkOutput("areset_src",   32'(cdbSrc),   32'h0);
    checkOutput("areset_count", 32'(cdbCount), 32'h0);
    checkOutput("areset_ready", 32'(reqReady), 32'h0);
    resetModel();
    reqValid = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] count wraparound");
    reqValid = 3'b111;
    for (int c = 0; c < 65535; c++) tick();
    checkOutput("count_ffff", 32'(cdbCount), 32'hFFFF);
    tick();
    checkOutput("count_wrap", 32'(cdbCount), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
